// File: rtl/apb_mem_slave_pkg.sv
// Shared widths, default depth and access classification for the APB byte-memory slave.
package apb_mem_slave_pkg;

    localparam int ADDR_W           = 7;
    localparam int DATA_W           = 8;
    localparam int MEM_SIZE_DEFAULT = 128;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_NOP,
        ACC_WRITE,
        ACC_READ,
        ACC_ERR
    } acc_kind_e;

    // An enabled cycle with neither direction requested is a no-op and never faults.
    function automatic acc_kind_e decode_access(
        input logic penable,
        input logic pwrite,
        input logic pread,
        input logic addr_oor,
        input logic ext_err
    );
        acc_kind_e kind;
        kind = ACC_IDLE;
        if (!penable) begin
            kind = ACC_IDLE;
        end else if (!pwrite && !pread) begin
            kind = ACC_NOP;
        end else if ((pwrite && pread) || addr_oor || ext_err) begin
            kind = ACC_ERR;
        end else if (pwrite) begin
            kind = ACC_WRITE;
        end else begin
            kind = ACC_READ;
        end
        return kind;
    endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// Bus bundle between the bridge master and the byte-memory slave.
interface apb_mem_slave_if;
    import apb_mem_slave_pkg::*;

    // Handshake: each rising edge with apb_penable high is one complete transfer;
    // the slave answers on that same edge with a one-cycle apb_pready pulse
    // (no wait states), and apb_prdata/apb_pslverr_out are valid while apb_pready is high.
    logic [ADDR_W-1:0] apb_paddr;
    logic              apb_pwrite;
    logic              apb_pread;
    logic              apb_penable;
    logic [DATA_W-1:0] apb_pwdata;
    logic              apb_pslverr;
    logic [DATA_W-1:0] apb_prdata;
    logic              apb_pready;
    logic              apb_pslverr_out;

    modport master (
        output apb_paddr,
        output apb_pwrite,
        output apb_pread,
        output apb_penable,
        output apb_pwdata,
        output apb_pslverr,
        input  apb_prdata,
        input  apb_pready,
        input  apb_pslverr_out
    );

    modport slave (
        input  apb_paddr,
        input  apb_pwrite,
        input  apb_pread,
        input  apb_penable,
        input  apb_pwdata,
        input  apb_pslverr,
        output apb_prdata,
        output apb_pready,
        output apb_pslverr_out
    );

endinterface

// File: rtl/apb_mem_array.sv
// MEM_SIZE x 8 storage with synchronous clear, one write port and a registered read port.
module apb_mem_array
    import apb_mem_slave_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [DATA_W-1:0] mem_q [MEM_SIZE];
    logic [DATA_W-1:0] mem_d [MEM_SIZE];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [IDX_W-1:0]  idx;

    // The caller only asserts we/re for in-range addresses, so truncation is safe.
    assign idx   = IDX_W'(addr);
    assign rdata = rdata_q;

    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (we) begin
            mem_d[idx] = wdata;
        end
        if (rd_clr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB-style byte-memory slave: decodes each enabled cycle, flags errors, pulses ready.
module apb_mem_slave
    import apb_mem_slave_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    apb_mem_slave_if.slave apb
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_SIZE);

    acc_kind_e kind;
    logic      addr_oor;
    logic      we;
    logic      re;
    logic      rd_clr;
    logic      pready_q;
    logic      pready_d;
    logic      pslverr_q;
    logic      pslverr_d;

    // One extra bit so MEM_SIZE=128 leaves every 7-bit address in range.
    assign addr_oor = ({1'b0, apb.apb_paddr} >= MEM_LIMIT);
    assign kind     = decode_access(apb.apb_penable, apb.apb_pwrite, apb.apb_pread,
                                    addr_oor, apb.apb_pslverr);

    always_comb begin
        we        = 1'b0;
        re        = 1'b0;
        rd_clr    = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        case (kind)
            ACC_NOP:   pready_d = 1'b1;
            ACC_WRITE: begin
                pready_d = 1'b1;
                we       = 1'b1;
            end
            ACC_READ: begin
                pready_d = 1'b1;
                re       = 1'b1;
            end
            ACC_ERR: begin
                pready_d  = 1'b1;
                pslverr_d = 1'b1;
                rd_clr    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    apb_mem_array #(
        .MEM_SIZE (MEM_SIZE)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .re     (re),
        .rd_clr (rd_clr),
        .addr   (apb.apb_paddr),
        .wdata  (apb.apb_pwdata),
        .rdata  (apb.apb_prdata)
    );

    assign apb.apb_pready      = pready_q;
    assign apb.apb_pslverr_out = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (128 and 64 locations) driven in lockstep against a reference model.
module tb_apb_mem_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apb_mem_slave_if bus_a ();
    apb_mem_slave_if bus_b ();

    apb_mem_slave #(.MEM_SIZE(128)) dut_a (.clk(clk), .rst(rst), .apb(bus_a));
    apb_mem_slave #(.MEM_SIZE(64))  dut_b (.clk(clk), .rst(rst), .apb(bus_b));

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    int         sizes[2] = '{128, 64};
    logic [7:0] mem_m[2][128];
    logic [7:0] prd_m[2];
    logic       rdy_m[2];
    logic       err_m[2];

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one slave of the given depth for one clock edge.
    task automatic model(input int d, input logic r, input logic en, input logic wr,
                         input logic rd, input int addr, input logic [7:0] wd, input logic slv);
        int  a;
        logic e;
        a = addr % 128;
        if (r) begin
            for (int i = 0; i < 128; i++) mem_m[d][i] = 8'h00;
            prd_m[d] = 8'h00;
            rdy_m[d] = 1'b0;
            err_m[d] = 1'b0;
        end else if (!en) begin
            rdy_m[d] = 1'b0;
            err_m[d] = 1'b0;
        end else if (!wr && !rd) begin
            rdy_m[d] = 1'b1;
            err_m[d] = 1'b0;
        end else begin
            e = (wr && rd) || (a >= sizes[d]) || slv;
            rdy_m[d] = 1'b1;
            err_m[d] = e;
            if (e) prd_m[d] = 8'h00;
            else if (wr) mem_m[d][a] = wd;
            else prd_m[d] = mem_m[d][a];
        end
        exp_q.push_back(prd_m[d]);
        exp_q.push_back({7'd0, rdy_m[d]});
        exp_q.push_back({7'd0, err_m[d]});
    endtask

    task automatic step(input string tag, input logic r, input logic en, input logic wr,
                        input logic rd, input int addr, input logic [7:0] wd, input logic slv);
        @(negedge clk);
        rst               = r;
        bus_a.apb_paddr   = 7'(addr);
        bus_a.apb_penable = en;
        bus_a.apb_pwrite  = wr;
        bus_a.apb_pread   = rd;
        bus_a.apb_pwdata  = wd;
        bus_a.apb_pslverr = slv;
        bus_b.apb_paddr   = 7'(addr);
        bus_b.apb_penable = en;
        bus_b.apb_pwrite  = wr;
        bus_b.apb_pread   = rd;
        bus_b.apb_pwdata  = wd;
        bus_b.apb_pslverr = slv;
        model(0, r, en, wr, rd, addr, wd, slv);
        model(1, r, en, wr, rd, addr, wd, slv);
        @(posedge clk);
        #1;
        check_val({tag, " m128 prdata"},  bus_a.apb_prdata,               exp_q.pop_front());
        check_val({tag, " m128 pready"},  {7'd0, bus_a.apb_pready},       exp_q.pop_front());
        check_val({tag, " m128 pslverr"}, {7'd0, bus_a.apb_pslverr_out},  exp_q.pop_front());
        check_val({tag, " m64 prdata"},   bus_b.apb_prdata,               exp_q.pop_front());
        check_val({tag, " m64 pready"},   {7'd0, bus_b.apb_pready},       exp_q.pop_front());
        check_val({tag, " m64 pslverr"},  {7'd0, bus_b.apb_pslverr_out},  exp_q.pop_front());
    endtask

    initial begin
        logic       r, en, wr, rd, slv;
        int         addr;
        logic [7:0] wd;

        bus_a.apb_paddr = '0; bus_a.apb_penable = 0; bus_a.apb_pwrite = 0;
        bus_a.apb_pread = 0;  bus_a.apb_pwdata  = '0; bus_a.apb_pslverr = 0;
        bus_b.apb_paddr = '0; bus_b.apb_penable = 0; bus_b.apb_pwrite = 0;
        bus_b.apb_pread = 0;  bus_b.apb_pwdata  = '0; bus_b.apb_pslverr = 0;

        step("reset0", 1, 0, 0, 0, 0, 8'h00, 0);
        step("reset1", 1, 1, 1, 0, 9, 8'h77, 0);
        step("rd100_after_reset", 0, 1, 0, 1, 100, 8'h00, 0);
        step("wr50", 0, 1, 1, 0, 50, 8'hAA, 0);
        step("wr51", 0, 1, 1, 0, 51, 8'hAB, 0);
        step("rd50", 0, 1, 0, 1, 50, 8'h00, 0);
        step("rd51", 0, 1, 0, 1, 51, 8'h00, 0);
        step("wr10_slverr", 0, 1, 1, 0, 10, 8'h55, 1);
        step("rd10", 0, 1, 0, 1, 10, 8'h00, 0);
        step("wr100", 0, 1, 1, 0, 100, 8'hBB, 0);
        step("rd100", 0, 1, 0, 1, 100, 8'h00, 0);
        step("wr5", 0, 1, 1, 0, 5, 8'h3C, 0);
        step("both5", 0, 1, 1, 1, 5, 8'hEE, 0);
        step("idle", 0, 0, 0, 0, 5, 8'h00, 0);
        step("rd5", 0, 1, 0, 1, 5, 8'h00, 0);
        step("nop", 0, 1, 0, 0, 5, 8'h00, 0);
        step("nop_slverr_oor", 0, 1, 0, 0, 90, 8'h00, 1);
        step("wr63", 0, 1, 1, 0, 63, 8'h63, 0);
        step("rd63", 0, 1, 0, 1, 63, 8'h00, 0);
        step("wr64", 0, 1, 1, 0, 64, 8'h64, 0);
        step("rd64", 0, 1, 0, 1, 64, 8'h00, 0);
        step("wr7", 0, 1, 1, 0, 7, 8'hCC, 0);
        step("rd7_before_rst", 0, 1, 0, 1, 7, 8'h00, 0);
        step("mid_rst", 1, 1, 0, 1, 7, 8'h00, 0);
        step("rd7_after_rst", 0, 1, 0, 1, 7, 8'h00, 0);
        step("wr_wrap130", 0, 1, 1, 0, 130, 8'h5A, 0);
        step("rd2", 0, 1, 0, 1, 2, 8'h00, 0);

        for (int n = 0; n < 2000; n++) begin
            r    = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 3) != 0);
            wr   = $urandom_range(0, 1);
            rd   = $urandom_range(0, 1);
            slv  = ($urandom_range(0, 15) == 0);
            addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 127))
                                               : int'($urandom_range(56, 72));
            wd   = 8'($urandom);
            step("rand", r, en, wr, rd, addr, wd, slv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Byte-wide, APB-style register-file slave: a peripheral-side memory of MEM_SIZE 8-bit locations, written and read through a simplified APB handshake. It is the storage endpoint behind the I2C-to-APB bridge: the bridge master drives address/control/data, and the block returns read data, a ready strobe and an error flag. All state is cleared by a synchronous reset.

## Interface
Parameters:
- MEM_SIZE, 128, number of byte locations; legal range 1..128 (address is 7 bits).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- apb_paddr  in  7  byte address.
- apb_pwrite  in  1  write request.
- apb_pread  in  1  read request.
- apb_penable  in  1  transfer enable; an access is sampled only when high.
- apb_pwdata  in  8  write data.
- apb_pslverr  in  1  external error request; forces the current access to fail.
- apb_prdata  out  8  registered read data.
- apb_pready  out  1  registered transfer-complete strobe.
- apb_pslverr_out  out  1  registered error flag for the completed access.

## Operation
- Access at a rising edge: apb_penable=1 and exactly one of apb_pwrite/apb_pread high.
- Error condition (err): apb_paddr >= MEM_SIZE, or apb_pslverr=1, or apb_penable=1 with apb_pwrite=apb_pread=1.
- Write access, no err: mem[apb_paddr] <= apb_pwdata.
- Read access, no err: apb_prdata <= mem[apb_paddr].
- On err: memory unchanged; apb_prdata <= 8'h00.
- Any cycle with apb_penable=1 (access or err case): apb_pready <= 1, apb_pslverr_out <= err.
- apb_penable=0: apb_pready <= 0, apb_pslverr_out <= 0, apb_prdata holds, memory holds.
- apb_penable=1 with neither pwrite nor pread: apb_pready <= 1, apb_pslverr_out <= 0, no memory change, apb_prdata holds.
- Reset: every memory location <= 8'h00; apb_prdata <= 8'h00; apb_pready <= 0; apb_pslverr_out <= 0. Reset has priority over any access in the same cycle.
- No wait states: every enabled access completes on the edge it is sampled.

## Timing
- Write latency: data visible in memory after the sampling edge; a read at the next enabled edge returns it (write-then-read back-to-back is legal).
- Read latency: apb_prdata, apb_pready, apb_pslverr_out valid immediately after the sampling edge (one edge from request).
- apb_pready is a one-cycle pulse per enabled cycle; holding apb_penable high for N edges produces N consecutive completions (each re-executed).
- Read and write of the same address on consecutive edges: read returns the newly written value.
- Reset asserted mid-transfer: transfer is discarded, outputs return to reset values on that edge.
- When MEM_SIZE=128 no address is out of range; 7-bit addresses wrap naturally (e.g. a driver value of 130 arrives as 2).

## Structure
- Shared package: ADDR_W=7, DATA_W=8 constants, default MEM_SIZE.
- One natural sub-module: apb_mem_array (MEM_SIZE x 8 storage with synchronous clear, write port, registered read port); top handles decode, error and ready logic.

## Test plan
- Reset then read addr 100 with penable -> prdata=8'h00, pready=1, pslverr_out=0.
- Write 8'hAA to 50, write 8'hAB to 51, then read 50 and 51 -> prdata 8'hAA then 8'hAB, pslverr_out=0 throughout.
- Write with apb_pslverr=1 to addr 10 (data 8'h55), then read 10 -> first access pslverr_out=1, memory unchanged, read returns 8'h00.
- MEM_SIZE=64: write 8'hBB to addr 100, then read 100 -> pslverr_out=1 both accesses, prdata=8'h00.
- pwrite=pread=penable=1 at addr 5 -> pslverr_out=1, mem[5] unchanged; penable=0 next cycle -> pready=0, pslverr_out=0.
- Write 8'hCC to addr 7, assert rst one cycle, read addr 7 -> prdata=8'h00 (memory cleared).
